// File: rtl/ov7670_downsampler.sv
// OV7670 RGB444 capture with 2:1 decimation in both directions.
// Pairs of camera bytes form one pixel; only even columns of even rows inside
// the active H_PIXELS x V_LINES window are written, giving a quarter-size frame
// at sequential addresses 0..FRAME_SIZE-1.
// Ports:
//   clk          camera PCLK, all logic on its rising edge
//   resetn       asynchronous active-low reset
//   config_done  camera configuration complete; low forces idle
//   cam_vsync    high between frames
//   cam_href     high while line bytes are valid
//   cam_data     camera byte
//   addr         write address of the current output pixel
//   wren         one-cycle write strobe qualifying addr/dout
//   dout         {4'b0, R, G, B}
//   frame_done   one-cycle pulse at end of each captured frame
//   frame_count  completed frames, wrapping
module ov7670_downsampler #(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int FRAME_SIZE = 76800
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        config_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [16:0] addr,
  output logic        wren,
  output logic [15:0] dout,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {WAIT_CFG, WAIT_FRAME, ACTIVE} state_t;

  localparam logic [11:0] H_LIM  = 12'(H_PIXELS);
  localparam logic [11:0] V_LIM  = 12'(V_LINES);
  localparam logic [16:0] FS_LIM = 17'(FRAME_SIZE);

  state_t      state_q, state_d;
  logic        vsync_prev_q, vsync_prev_d;
  logic        href_prev_q, href_prev_d;
  logic        phase_q, phase_d;
  logic [11:0] col_q, col_d;
  logic [11:0] row_q, row_d;
  logic [3:0]  red_q, red_d;
  logic [16:0] cnt_q, cnt_d;
  logic [16:0] addr_q, addr_d;
  logic        wren_q, wren_d;
  logic [15:0] dout_q, dout_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic vs_rise, vs_fall, href_rise, href_fall, cur_phase, keep;

  always_comb begin
    vs_rise   = ~vsync_prev_q & cam_vsync;
    vs_fall   = vsync_prev_q & ~cam_vsync;
    href_rise = ~href_prev_q & cam_href;
    href_fall = href_prev_q & ~cam_href;
    // The first byte after HREF rises is always a high byte, whatever the
    // phase flop still holds from a previous odd-length line.
    cur_phase = href_rise ? 1'b0 : phase_q;
    // cnt_q counts pixels already written, so it doubles as the saturation test.
    keep      = ~col_q[0] & ~row_q[0] & (col_q < H_LIM) & (row_q < V_LIM) &
                (cnt_q < FS_LIM);

    state_d       = state_q;
    vsync_prev_d  = cam_vsync;
    href_prev_d   = cam_href;
    phase_d       = phase_q;
    col_d         = col_q;
    row_d         = row_q;
    red_d         = red_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wren_d        = 1'b0;
    dout_d        = dout_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    if (!config_done) begin
      state_d = WAIT_CFG;
    end else begin
      unique case (state_q)
        WAIT_CFG: state_d = WAIT_FRAME;
        WAIT_FRAME: begin
          if (vs_fall) begin
            state_d = ACTIVE;
            phase_d = 1'b0;
            col_d   = '0;
            row_d   = '0;
            cnt_d   = '0;
            addr_d  = '0;
          end
        end
        ACTIVE: begin
          if (cam_href) begin
            if (!cur_phase) begin
              red_d   = cam_data[3:0];
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (col_q != '1) col_d = col_q + 12'd1;
              if (keep) begin
                wren_d = 1'b1;
                addr_d = cnt_q;
                dout_d = {4'b0000, red_q, cam_data};
                cnt_d  = cnt_q + 17'd1;
              end
            end
          end else if (href_fall) begin
            phase_d = 1'b0;
            col_d   = '0;
            if (row_q != '1) row_d = row_q + 12'd1;
          end
          // A pixel finishing on this same sample is still written above.
          if (vs_rise) begin
            state_d       = WAIT_FRAME;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end
        end
        default: state_d = WAIT_CFG;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= WAIT_CFG;
      vsync_prev_q  <= 1'b0;
      href_prev_q   <= 1'b0;
      phase_q       <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      red_q         <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      wren_q        <= 1'b0;
      dout_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      vsync_prev_q  <= vsync_prev_d;
      href_prev_q   <= href_prev_d;
      phase_q       <= phase_d;
      col_q         <= col_d;
      row_q         <= row_d;
      red_q         <= red_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wren_q        <= wren_d;
      dout_q        <= dout_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign addr        = addr_q;
  assign wren        = wren_q;
  assign dout        = dout_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ov7670_downsampler.sv
// Bench for ov7670_downsampler on a scaled 16x8 sensor window (32 output
// pixels). Stimulus pushes expected {addr, dout} writes into a queue; an
// independent monitor pops one entry per wren.
module tb_ov7670_downsampler;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int FS = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        config_done = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic [16:0] addr;
  logic        wren;
  logic [15:0] dout;
  logic        frame_done;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  ov7670_downsampler #(
    .H_PIXELS  (H),
    .V_LINES   (V),
    .FRAME_SIZE(FS)
  ) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .config_done(config_done),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .addr       (addr),
    .wren       (wren),
    .dout       (dout),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  typedef struct packed {
    logic [16:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t exp_e;
  int  checks = 0;
  int  errors = 0;
  int  wr_seen = 0;
  int  fd_seen = 0;
  int  both_seen = 0;
  int  exp_wr = 0;
  int  exp_cnt = 0;
  bit  model_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every wren must match the oldest expected write.
  always @(negedge clk) begin
    if (resetn && wren) begin
      wr_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wren: got addr=%0d dout=%h expected no write", addr, dout);
      end else begin
        exp_e = sb.pop_front();
        if (addr !== exp_e.a || dout !== exp_e.d) begin
          errors++;
          $display("FAIL write: got addr=%0d dout=%h expected addr=%0d dout=%h",
                   addr, dout, exp_e.a, exp_e.d);
        end
      end
    end
    if (resetn && frame_done) fd_seen++;
    if (resetn && frame_done && wren) both_seen++;
  end

  // Incrementing byte stream, with the directed first-line bytes
  // 0x0A,0xBC,0x01,0x23 at the start of row 0.
  function automatic logic [7:0] pat(input int r, input int c, input int k);
    if (r == 0 && c == 0) return (k == 0) ? 8'h0A : 8'hBC;
    if (r == 0 && c == 1) return (k == 0) ? 8'h01 : 8'h23;
    return 8'((r * 64 + c * 2 + k) & 255);
  endfunction

  task automatic start_frame();
    cam_vsync = 1'b1;
    repeat (3) @(negedge clk);
    cam_vsync = 1'b0;
    exp_cnt = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic end_frame();
    cam_vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_line(input int r, input int pix, input bit odd_tail, input bit vs_last);
    logic [7:0] hi, lo;
    for (int c = 0; c < pix; c++) begin
      hi = pat(r, c, 0);
      lo = pat(r, c, 1);
      cam_href = 1'b1;
      cam_data = hi;
      @(negedge clk);
      cam_data = lo;
      if (vs_last && c == pix - 1) cam_vsync = 1'b1;
      if (model_on && r % 2 == 0 && c % 2 == 0 && c < H && r < V && exp_cnt < FS) begin
        sb.push_back({17'(exp_cnt), 4'h0, hi[3:0], lo});
        exp_cnt++;
        exp_wr++;
      end
      @(negedge clk);
    end
    if (odd_tail) begin
      cam_data = 8'hEE;
      @(negedge clk);
    end
    cam_href = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input int lines, input int pix, input bit odd);
    start_frame();
    for (int r = 0; r < lines; r++) send_line(r, pix, odd && (r % 3 == 0), 1'b0);
    end_frame();
  endtask

  task automatic check_frame(input int fc, input int fd);
    check("write_count", wr_seen, exp_wr);
    check("sb_empty", sb.size(), 0);
    check("frame_count", int'(frame_count), fc);
    check("frame_done_pulses", fd_seen, fd);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_addr", int'(addr), 0);
    check("rst_wren", int'(wren), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_count", int'(frame_count), 0);

    // Frame traffic while unconfigured must be ignored.
    resetn = 1'b1;
    @(negedge clk);
    run_frame(V, H, 1'b0);
    check_frame(0, 0);

    // Nominal frame, including the directed first-line bytes.
    model_on = 1'b1;
    config_done = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(V, H, 1'b0);
    check_frame(1, 1);
    check("last_addr_nominal", int'(addr), FS - 1);

    // Oversized frame with odd trailing bytes on some lines.
    run_frame(V + 2, H + 4, 1'b1);
    check_frame(2, 2);
    check("last_addr_oversize", int'(addr), FS - 1);

    // Short frame ending with VSYNC rising on a kept pixel's low byte.
    start_frame();
    send_line(0, H, 1'b0, 1'b0);
    send_line(1, H, 1'b0, 1'b0);
    send_line(2, 1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_frame(3, 3);
    check("write_with_frame_done", both_seen, 1);

    // config_done dropped mid-frame, then a clean frame restarting at addr 0.
    start_frame();
    for (int r = 0; r < 4; r++) send_line(r, H, 1'b0, 1'b0);
    config_done = 1'b0;
    model_on = 1'b0;
    for (int r = 4; r < V; r++) send_line(r, H, 1'b0, 1'b0);
    end_frame();
    check_frame(3, 3);
    config_done = 1'b1;
    model_on = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(V, H, 1'b0);
    check_frame(4, 4);

    // Reset mid-frame.
    start_frame();
    for (int r = 0; r < 5; r++) send_line(r, H, 1'b0, 1'b0);
    check("addr_before_reset", int'(addr), 23);
    resetn = 1'b0;
    #1;
    check("mid_rst_addr", int'(addr), 0);
    check("mid_rst_wren", int'(wren), 0);
    check("mid_rst_dout", int'(dout), 0);
    check("mid_rst_frame_done", int'(frame_done), 0);
    check("mid_rst_frame_count", int'(frame_count), 0);
    @(negedge clk);
    resetn = 1'b1;
    model_on = 1'b0;
    for (int r = 5; r < V; r++) send_line(r, H, 1'b0, 1'b0);
    end_frame();
    check_frame(0, 4);
    model_on = 1'b1;
    run_frame(V, H, 1'b0);
    check_frame(1, 5);
    check("last_addr_after_reset", int'(addr), FS - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ov7670_downsampler.md
OV7670_DOWNSAMPLER -- requirements
Module: ov7670_downsampler

Interface
REQ-001 Parameter H_PIXELS, default 640: active pixels per camera line.
REQ-002 Parameter V_LINES, default 480: active lines per camera frame.
REQ-003 Parameter FRAME_SIZE, default 76800: output pixels per frame, (H_PIXELS/2)*(V_LINES/2).
REQ-004 clk  input  1  sole clock (camera PCLK); all logic on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 config_done  input  1  high once camera I2C configuration is complete.
REQ-007 cam_vsync  input  1  camera VSYNC; high between frames.
REQ-008 cam_href  input  1  camera HREF; high while a line's bytes are valid.
REQ-009 cam_data  input  8  camera data byte, sampled each rising edge of clk.
REQ-010 addr  output  17  write address of the output pixel, 0..FRAME_SIZE-1.
REQ-011 wren  output  1  one-cycle write strobe; addr and dout valid while high.
REQ-012 dout  output  16  pixel {4'b0, R[3:0], G[3:0], B[3:0]}.
REQ-013 frame_done  output  1  one-cycle pulse at end of each captured frame.
REQ-014 frame_count  output  16  count of completed frames, wraps at 65535 to 0.

Function
REQ-015 State machine SHALL have three states: WAIT_CFG, WAIT_FRAME and ACTIVE.
REQ-016 WAIT_CFG -> WAIT_FRAME when config_done is sampled high.
REQ-017 WAIT_FRAME -> ACTIVE on a cam_vsync falling edge (previous sample 1, current sample 0); column counter, row counter, byte phase and addr cleared to 0.
REQ-018 ACTIVE -> WAIT_FRAME on a cam_vsync rising edge; frame_done pulses high for exactly one cycle; frame_count increments.
REQ-019 Any state -> WAIT_CFG within one cycle when config_done is sampled low; no wren or frame_done is issued on that transition.
REQ-020 In ACTIVE, the byte phase toggles on each cycle with cam_href high and resets to 0 on each cam_href rising edge.
REQ-021 Phase-0 byte is the high byte (bits [3:0] = R); phase-1 byte is the low byte ([7:4] = G, [3:0] = B).
REQ-022 A pixel completes on each phase-1 byte; the column counter increments after each completed pixel.
REQ-023 Column counter clears on each cam_href falling edge; the row counter increments on that edge.
REQ-024 A completed pixel is kept only if column[0]==0 and row[0]==0 and column<H_PIXELS and row<V_LINES.
REQ-025 A kept pixel drives wren=1, dout and addr in the cycle immediately after the phase-1 byte is sampled (latency 1).
REQ-026 addr increments by 1 after each kept pixel and saturates at FRAME_SIZE-1; once FRAME_SIZE pixels are written, further kept pixels produce no wren.
REQ-027 Excess columns (>=H_PIXELS), excess rows (>=V_LINES) and odd trailing bytes at cam_href fall SHALL be discarded without wren.
REQ-028 A frame shorter than V_LINES still ends on the cam_vsync rising edge with frame_done; the remaining addresses are simply not written.
REQ-029 No wren SHALL be issued in WAIT_CFG or WAIT_FRAME, even if cam_href toggles.
REQ-030 A cam_vsync rising edge while a pixel's low byte is being sampled: that pixel's wren SHALL still be issued, then frame_done pulses in the same cycle.

Reset
REQ-031 resetn low asynchronously forces state WAIT_CFG and sets addr=0, wren=0, dout=0, frame_done=0, frame_count=0, and clears all internal counters and edge-detect registers to 0.
REQ-032 Reset mid-frame abandons the frame; after release the block waits for config_done and the next cam_vsync falling edge.

Verification
REQ-033 Reset release with config_done=0 and an active frame driven -> no wren, frame_count stays 0.
REQ-034 config_done=1, one full 640x480 frame of incrementing bytes -> exactly 76800 wren pulses, addr 0..76799 monotonic, one frame_done, frame_count=1.
REQ-035 First line bytes 0x0A,0xBC,0x01,0x23 -> first write addr=0, dout=0x0ABC; pixel 0x0123 not written.
REQ-036 Frame with 700-pixel lines and 500 lines -> still 76800 writes, last addr=76799, no writes past it.
REQ-037 config_done dropped mid-frame at row 100 -> wren stops within 1 cycle; after re-raise, the next frame restarts at addr=0.
REQ-038 resetn asserted at row 200 then released -> all outputs 0 immediately; the next full frame yields 76800 writes and frame_count=1.
